// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : divider_pkg
// Brief    : Shared widths, opcode encodings, FSM states and helpers for the
//            RV32M iterative divider.
// Revision : 1.0 - initial release
// ============================================================================
package divider_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int CNT_W      = $clog2(DATA_WIDTH);

   // funct3[1:0] of the M-extension divide group
   localparam logic [1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [1:0] DIV_OP_REM  = 2'b10;
   localparam logic [1:0] DIV_OP_REMU = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   function automatic logic [DATA_WIDTH-1:0] cond_negate(
      input logic [DATA_WIDTH-1:0] x,
      input logic                  neg
   );
      return neg ? -x : x;
   endfunction

endpackage
`default_nettype wire

// File: rtl/divider_core.sv
`default_nettype none
// ============================================================================
// Module   : divider_core
// Brief    : Unsigned radix-2 restoring division engine, one quotient bit per
//            step. Exposes the next-step values so the caller can capture the
//            final result on the last step without an extra cycle.
// Revision : 1.0 - initial release
// ============================================================================
module divider_core
   import divider_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  step,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic [DATA_WIDTH-1:0] quo_next,
   output logic [DATA_WIDTH-1:0] rem_next,
   output logic                  last
);

   logic [DATA_WIDTH-1:0] r_rem;
   logic [DATA_WIDTH-1:0] r_quo;
   logic [DATA_WIDTH-1:0] r_dvs;
   logic [CNT_W-1:0]      r_cnt;

   logic [DATA_WIDTH:0]   w_shift;
   logic [DATA_WIDTH:0]   w_trial;

   // R < divisor always holds, so the W+1 bit trial difference never wraps
   // and its MSB is a valid sign bit.
   always_comb begin
      w_shift  = {r_rem, r_quo[DATA_WIDTH-1]};
      w_trial  = w_shift - {1'b0, r_dvs};
      rem_next = w_shift[DATA_WIDTH-1:0];
      quo_next = {r_quo[DATA_WIDTH-2:0], 1'b0};
      if (!w_trial[DATA_WIDTH]) begin
         rem_next = w_trial[DATA_WIDTH-1:0];
         quo_next = {r_quo[DATA_WIDTH-2:0], 1'b1};
      end
   end

   assign last = (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem <= '0;
         r_quo <= '0;
         r_dvs <= '0;
         r_cnt <= '0;
      end else if (load) begin
         r_quo <= dividend;
         r_rem <= '0;
         r_dvs <= divisor;
         r_cnt <= CNT_W'(DATA_WIDTH - 1);
      end else if (step) begin
         r_quo <= quo_next;
         r_rem <= rem_next;
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
// Module   : divider
// Brief    : RV32M DIV/DIVU/REM/REMU unit with the multiplier's req/stall
//            handshake. Optional early-out build: DIVIDER_FAST_PATH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module divider
   import divider_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic [1:0]            opcode,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] o,
   output logic                  stall
);

   div_state_t            r_state;
   logic                  r_sign_a;
   logic                  r_sign_b;
   logic                  r_rem_sel;
   logic                  r_b_zero;

   logic                  w_busy;
   logic                  w_done;
   logic                  w_new_req;
   logic                  w_sign_a;
   logic                  w_sign_b;
   logic                  w_b_zero;
   logic                  w_fast;
   logic [DATA_WIDTH-1:0] w_abs_a;
   logic [DATA_WIDTH-1:0] w_abs_b;
   logic [DATA_WIDTH-1:0] w_quo_next;
   logic [DATA_WIDTH-1:0] w_rem_next;
   logic                  w_last;
   logic [DATA_WIDTH-1:0] w_quo_fix;
   logic [DATA_WIDTH-1:0] w_rem_fix;

   assign w_busy    = (r_state != IDLE);
   assign w_done    = (r_state == DONE);
   assign w_new_req = req & ~w_busy;
   assign stall     = w_new_req | (w_busy & ~w_done);

   // Signs only matter for DIV/REM (opcode[0] clear).
   assign w_sign_a = ~opcode[0] & a[DATA_WIDTH-1];
   assign w_sign_b = ~opcode[0] & b[DATA_WIDTH-1];
   assign w_abs_a  = cond_negate(a, w_sign_a);
   assign w_abs_b  = cond_negate(b, w_sign_b);
   assign w_b_zero = (b == '0);

`ifdef DIVIDER_FAST_PATH_EN
   assign w_fast = w_b_zero | (w_abs_a < w_abs_b);
`else
   assign w_fast = 1'b0;
`endif

   divider_core u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (w_new_req),
      .step     (r_state == CALC),
      .dividend (w_abs_a),
      .divisor  (w_abs_b),
      .quo_next (w_quo_next),
      .rem_next (w_rem_next),
      .last     (w_last)
   );

   // A zero divisor leaves the all-ones quotient un-negated; the overflow
   // case needs no special handling since -0x80000000 wraps to itself.
   assign w_quo_fix = cond_negate(w_quo_next, (r_sign_a ^ r_sign_b) & ~r_b_zero);
   assign w_rem_fix = cond_negate(w_rem_next, r_sign_a);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         o         <= '0;
         r_sign_a  <= 1'b0;
         r_sign_b  <= 1'b0;
         r_rem_sel <= 1'b0;
         r_b_zero  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_new_req) begin
                  r_sign_a  <= w_sign_a;
                  r_sign_b  <= w_sign_b;
                  r_rem_sel <= opcode[1];
                  r_b_zero  <= w_b_zero;
                  if (w_fast) begin
                     o       <= opcode[1] ? a : (w_b_zero ? '1 : '0);
                     r_state <= DONE;
                  end else begin
                     r_state <= CALC;
                  end
               end
            end
            CALC: begin
               if (w_last) begin
                  o       <= r_rem_sel ? w_rem_fix : w_quo_fix;
                  r_state <= DONE;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
